// File: rtl/wb_arb2.sv
// wb_arb2 -- two-master, single-slave Wishbone arbiter in front of the on-chip RAM.
//
// Master 0 is the CPU instruction bus, master 1 the CPU data bus. A master is granted for a
// whole bus cycle (while its cyc stays high). Ties in IDLE go to the master that did not win
// last. A granted strobe that waits TIMEOUT cycles without a slave ack is terminated with a
// one-cycle err pulse to that master, and the arbiter returns to IDLE.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   m{0,1}_cyc_i/stb_i/we_i   master cycle / strobe / write enable
//   m{0,1}_sel_i [3:0]        master byte selects
//   m{0,1}_adr_i [31:0]       master address
//   m{0,1}_dat_i [31:0]       master write data
//   m{0,1}_dat_o [31:0]       master read data (slave data passed straight through)
//   m{0,1}_ack_o              master ack (only the granted master sees it)
//   m{0,1}_err_o              master timeout error (registered, one-cycle pulse)
//   s_cyc_o/stb_o/we_o        slave cycle / strobe / write enable
//   s_sel_o [3:0]             slave byte selects
//   s_adr_o [31:0]            slave address
//   s_dat_o [31:0]            slave write data
//   s_dat_i [31:0]            slave read data
//   s_ack_i                   slave ack
//
// TIMEOUT must fit the counter: 2**CNT_W > TIMEOUT.

module wb_arb2 #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntLimit = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;     // master granted most recently; loser of next tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m0_err_q, m0_err_d;
  logic             m1_err_q, m1_err_d;

  logic             granted;
  logic             waiting;            // granted strobe outstanding, no ack this cycle
  logic             expire;             // last waiting cycle before the timeout fires

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      m0_err_q <= m0_err_d;
      m1_err_q <= m1_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout qualification
  // ---------------------------------------------------------------------------
  assign granted = (state_q != StIdle);
  // An ack in the limit cycle clears waiting, so ack wins over err.
  assign waiting = granted & s_cyc_o & s_stb_o & ~s_ack_i;
  assign expire  = waiting & (cnt_q == CntLimit);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = '0;
    m0_err_d = 1'b0;
    m1_err_d = 1'b0;

    if (waiting && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = StGnt0;
            last_d  = 1'b0;
          end else begin
            state_d = StGnt1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = StGnt0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
          last_d  = 1'b1;
        end
      end
      StGnt0: begin
        m0_err_d = expire;
        if (!m0_cyc_i || expire) begin
          state_d = StIdle;
        end
      end
      StGnt1: begin
        m1_err_d = expire;
        if (!m1_cyc_i || expire) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: slave-side mux and response routing, decoded from state only
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;

    unique case (state_q)
      StGnt0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
      end
      StGnt1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;

endmodule

// File: tb/tb_wb_arb2.sv
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic        s_ack;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e;

  int ack_delay = 1;   // 0: slave never acks
  int sc;

  always #5 clk = ~clk;

  wb_arb2 #(.TIMEOUT(4), .CNT_W(3)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_dat_w),
    .m0_dat_o (m0_dat_r),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_dat_w),
    .m1_dat_o (m1_dat_r),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat_w),
    .s_dat_i  (s_dat_r),
    .s_ack_i  (s_ack)
  );

  // Slave model: read data is a fixed function of the address.
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
  endfunction

  assign s_dat_r = slave_rd(s_adr);

  // Registered ack, ack_delay cycles after strobe, held one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0;
      sc    <= 0;
    end else if (s_cyc && s_stb && !s_ack && ack_delay != 0) begin
      if (sc + 1 == ack_delay) begin
        s_ack <= 1'b1;
        sc    <= 0;
      end else begin
        sc <= sc + 1;
      end
    end else begin
      s_ack <= 1'b0;
      sc    <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic m0_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_w = dat;
  endtask

  task automatic m1_set(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_w = dat;
  endtask

  task automatic push(input int m, input logic err, input logic chk_dat, input logic [31:0] dat);
    exp_t x;
    x.err = err; x.chk_dat = chk_dat; x.dat = dat;
    if (m == 0) sb0.push_back(x);
    else sb1.push_back(x);
  endtask

  // Scoreboard: every ack/err pops the expectation queued for that master.
  always @(negedge clk) begin
    if (!rst && (m0_ack || m1_ack || m0_err || m1_err)) begin
      chk("resp_both_masters", {31'b0, (m0_ack | m0_err) & (m1_ack | m1_err)}, 32'd0);
      if (m0_ack || m0_err) begin
        if (sb0.size() == 0) chk("resp_unexpected_m0", 32'd1, 32'd0);
        else begin
          e = sb0.pop_front();
          chk("resp_err_m0", {31'b0, m0_err}, {31'b0, e.err});
          if (!m0_err && e.chk_dat) chk("resp_rdata_m0", m0_dat_r, e.dat);
        end
      end
      if (m1_ack || m1_err) begin
        if (sb1.size() == 0) chk("resp_unexpected_m1", 32'd1, 32'd0);
        else begin
          e = sb1.pop_front();
          chk("resp_err_m1", {31'b0, m1_err}, {31'b0, e.err});
          if (!m1_err && e.chk_dat) chk("resp_rdata_m1", m1_dat_r, e.dat);
        end
      end
    end
  end

  initial begin
    m0_set(0, 0, 0, 32'h0, 4'h0, 32'h0);
    m1_set(0, 0, 0, 32'h0, 4'h0, 32'h0);

    // Reset state
    step();
    chk("rst_s_cyc", {31'b0, s_cyc}, 32'd0);
    chk("rst_s_stb", {31'b0, s_stb}, 32'd0);
    chk("rst_s_sel", {28'b0, s_sel}, 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    chk("rst_acks", {30'b0, m0_ack, m1_ack}, 32'd0);
    chk("rst_errs", {30'b0, m0_err, m1_err}, 32'd0);
    chk("rst_dat_pass", m0_dat_r, 32'hC0DE_0000);
    rst = 1'b0;

    // Single read, m0 only
    step();
    m0_set(1, 1, 0, 32'h10, 4'hF, 32'h0);
    push(0, 0, 1, 32'h1234_5678);
    #1 chk("t1_no_same_cycle_grant", {31'b0, s_cyc}, 32'd0);
    step();
    chk("t1_grant", {31'b0, s_cyc}, 32'd1);
    chk("t1_s_adr", s_adr, 32'h10);
    step();
    chk("t1_m0_ack", {31'b0, m0_ack}, 32'd1);
    chk("t1_m1_quiet", {31'b0, m1_ack}, 32'd0);
    m0_set(0, 0, 0, 32'h10, 4'hF, 32'h0);
    step();
    chk("t1_idle", {31'b0, s_cyc}, 32'd0);

    // Tie after reset, then rotation
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_set(1, 1, 0, 32'h100, 4'hF, 32'h0);
    m1_set(1, 1, 0, 32'h200, 4'hF, 32'h0);
    push(0, 0, 1, slave_rd(32'h100));
    push(1, 0, 1, slave_rd(32'h200));
    step();
    chk("t2_tie_m0", s_adr, 32'h100);
    step();
    m0_set(0, 0, 0, 32'h100, 4'hF, 32'h0);
    step();
    chk("t2_idle_gap", {31'b0, s_cyc}, 32'd0);
    m0_set(1, 1, 0, 32'h104, 4'hF, 32'h0);
    push(0, 0, 1, slave_rd(32'h104));
    step();
    chk("t2_rot_m1", s_adr, 32'h200);
    step();
    m1_set(0, 0, 0, 32'h200, 4'hF, 32'h0);
    step();
    chk("t2_idle_gap2", {31'b0, s_cyc}, 32'd0);
    m1_set(1, 1, 0, 32'h204, 4'hF, 32'h0);
    push(1, 0, 1, slave_rd(32'h204));
    step();
    chk("t2_tie_back_m0", s_adr, 32'h104);
    step();
    m0_set(0, 0, 0, 32'h104, 4'hF, 32'h0);
    step();
    step();
    chk("t2_m1_after", s_adr, 32'h204);
    step();
    m1_set(0, 0, 0, 32'h204, 4'hF, 32'h0);
    step();

    // Grant hold: m1 three back-to-back writes while m0 waits
    m1_set(1, 1, 1, 32'h400, 4'hF, 32'hAAAA_0001);
    push(1, 0, 0, 32'h0);
    step();
    m0_set(1, 1, 0, 32'h300, 4'hF, 32'h0);
    push(0, 0, 1, slave_rd(32'h300));
    chk("t3_sel_f", {28'b0, s_sel}, 32'hF);
    chk("t3_we", {31'b0, s_we}, 32'd1);
    chk("t3_wdat", s_dat_w, 32'hAAAA_0001);
    step();
    m1_set(1, 1, 1, 32'h404, 4'h1, 32'hAAAA_0002);
    push(1, 0, 0, 32'h0);
    step();
    chk("t3_sel_1", {28'b0, s_sel}, 32'h1);
    chk("t3_hold_adr", s_adr, 32'h404);
    step();
    m1_set(1, 1, 1, 32'h408, 4'hC, 32'hAAAA_0003);
    push(1, 0, 0, 32'h0);
    step();
    chk("t3_sel_c", {28'b0, s_sel}, 32'hC);
    chk("t3_hold_adr2", s_adr, 32'h408);
    step();
    m1_set(0, 0, 0, 32'h408, 4'hC, 32'h0);
    step();
    chk("t3_idle", {31'b0, s_cyc}, 32'd0);
    step();
    chk("t3_m0_granted", s_adr, 32'h300);
    chk("t3_m0_read", {31'b0, s_we}, 32'd0);
    step();
    m0_set(0, 0, 0, 32'h300, 4'hF, 32'h0);
    step();

    // Timeout: slave never acks, TIMEOUT = 4
    ack_delay = 0;
    m0_set(1, 1, 0, 32'h500, 4'hF, 32'h0);
    push(0, 1, 0, 32'h0);
    step();
    chk("t4_stb_up", {31'b0, s_stb}, 32'd1);
    step();
    step();
    step();
    chk("t4_no_err_early", {31'b0, m0_err}, 32'd0);
    chk("t4_stb_held", {31'b0, s_stb}, 32'd1);
    step();
    chk("t4_err_pulse", {31'b0, m0_err}, 32'd1);
    chk("t4_idle_after_err", {31'b0, s_cyc}, 32'd0);
    m0_set(0, 0, 0, 32'h500, 4'hF, 32'h0);
    step();
    chk("t4_err_one_cycle", {31'b0, m0_err}, 32'd0);

    // Ack in the limit cycle wins over err
    ack_delay = 3;
    m1_set(1, 1, 0, 32'h600, 4'hF, 32'h0);
    push(1, 0, 1, slave_rd(32'h600));
    step();
    step();
    step();
    step();
    chk("t5_ack_at_limit", {31'b0, m1_ack}, 32'd1);
    m1_set(0, 0, 0, 32'h600, 4'hF, 32'h0);
    step();
    chk("t5_no_err", {31'b0, m1_err}, 32'd0);

    // Reset mid-transaction
    ack_delay = 0;
    step();
    m1_set(1, 1, 0, 32'h700, 4'hF, 32'h0);
    step();
    chk("t6_stb_before_rst", {31'b0, s_stb}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cyc", {31'b0, s_cyc}, 32'd0);
    chk("t6_async_stb", {31'b0, s_stb}, 32'd0);
    ack_delay = 1;
    m0_set(1, 1, 0, 32'h800, 4'hF, 32'h0);
    push(0, 0, 1, slave_rd(32'h800));
    step();
    chk("t6_no_resp", {28'b0, m0_ack, m1_ack, m0_err, m1_err}, 32'd0);
    rst = 1'b0;
    step();
    chk("t6_tie_m0", s_adr, 32'h800);
    m1_set(0, 0, 0, 32'h700, 4'hF, 32'h0);
    step();
    m0_set(0, 0, 0, 32'h800, 4'hF, 32'h0);
    step();
    step();

    chk("sb0_drain", sb0.size(), 32'd0);
    chk("sb1_drain", sb1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
